// File: rtl/cpu_control_fsm_pkg.sv
// Shared definitions for the CPU control sequencer.
//   - 3-bit state encodings (also exported on the debug state port)
//   - RV32I major opcode constants
//   - instruction class encoding registered by the sequencer in DECODE
package cpu_ctrl_pkg;

    localparam logic [2:0] FETCH     = 3'd0;
    localparam logic [2:0] DECODE    = 3'd1;
    localparam logic [2:0] EXECUTE   = 3'd2;
    localparam logic [2:0] MEMORY    = 3'd3;
    localparam logic [2:0] WRITEBACK = 3'd4;
    localparam logic [2:0] HALT      = 3'd5;
    localparam logic [2:0] TRAP      = 3'd6;

    typedef enum logic [2:0] {
        ST_FETCH     = FETCH,
        ST_DECODE    = DECODE,
        ST_EXECUTE   = EXECUTE,
        ST_MEMORY    = MEMORY,
        ST_WRITEBACK = WRITEBACK,
        ST_HALT      = HALT,
        ST_TRAP      = TRAP
    } state_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_OP_IMM,
        CLS_OP,
        CLS_FENCE,
        CLS_SYSTEM
    } cls_t;

    function automatic logic is_jump(cls_t c);
        return (c == CLS_JAL) || (c == CLS_JALR);
    endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control/handshake bundle between the sequencer and the datapath/memories.
//   master : the sequencer (drives requests, enables, status, debug state)
//   slave  : datapath + memory side (drives instr, ready strobes, branch result)
interface cpu_control_fsm_if;

    logic [31:0] instr;
    logic        pmem_req;
    logic        pmem_ready;
    logic        ir_load;
    logic        opd_load;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        branch_taken;
    logic        rf_we;
    logic        pc_inc;
    logic        pc_load;
    logic        instr_retired;
    logic        halted;
    logic        illegal_instr;
    logic        bus_error;
    logic [2:0]  state;

    modport master (
        input  instr, pmem_ready, dmem_ready, branch_taken,
        output pmem_req, ir_load, opd_load, dmem_req, dmem_we, rf_we,
               pc_inc, pc_load, instr_retired, halted, illegal_instr,
               bus_error, state
    );

    modport slave (
        output instr, pmem_ready, dmem_ready, branch_taken,
        input  pmem_req, ir_load, opd_load, dmem_req, dmem_we, rf_we,
               pc_inc, pc_load, instr_retired, halted, illegal_instr,
               bus_error, state
    );

endinterface

// File: rtl/cpu_control_fsm_opcode_classifier.sv
// Combinational RV32I major-opcode classifier.
//   opcode  : instr[6:0]
//   cls     : instruction class (CLS_NONE for unsupported opcodes)
//   illegal : opcode not supported
//   system  : ECALL/EBREAK group
module opcode_classifier
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output cls_t       cls,
    output logic       illegal,
    output logic       system
);

    always_comb begin
        cls     = CLS_NONE;
        illegal = 1'b0;
        system  = 1'b0;
        unique case (opcode)
            OPC_LUI:      cls = CLS_LUI;
            OPC_AUIPC:    cls = CLS_AUIPC;
            OPC_JAL:      cls = CLS_JAL;
            OPC_JALR:     cls = CLS_JALR;
            OPC_BRANCH:   cls = CLS_BRANCH;
            OPC_LOAD:     cls = CLS_LOAD;
            OPC_STORE:    cls = CLS_STORE;
            OPC_OP_IMM:   cls = CLS_OP_IMM;
            OPC_OP:       cls = CLS_OP;
            OPC_MISC_MEM: cls = CLS_FENCE;
            OPC_SYSTEM: begin
                cls    = CLS_SYSTEM;
                system = 1'b1;
            end
            default:      illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control sequencer: fetch, decode, execute, memory,
// writeback, plus halt/trap terminal states and a memory-wait timeout.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset; forces every output low while high
//   bus  : cpu_control_fsm_if.master (requests, enables, status, debug state)
// Parameter MEM_TIMEOUT: max wait cycles per pmem/dmem request (0 = no limit).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | pmem request; IR captured on pmem_ready
// DECODE    | classify opcode, load operand registers
// EXECUTE   | ALU step; branches retire here
// MEMORY    | dmem request; stores retire on dmem_ready
// WRITEBACK | register write, PC update, retire
// HALT      | ECALL/EBREAK seen; held until rst
// TRAP      | illegal opcode or bus timeout; held until rst
module cpu_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    cpu_control_fsm_if.master   bus
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic TO_EN = (MEM_TIMEOUT > 0);

    state_t        state_q, state_d;
    cls_t          cls_q;
    logic          rd_zero_q;
    logic          ill_q, berr_q;
    logic          set_ill, set_berr;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_hit;

    cls_t          dec_cls;
    logic          dec_illegal, dec_system;

    logic          pmem_req_c, ir_load_c, opd_load_c, dmem_req_c, dmem_we_c;
    logic          rf_we_c, pc_inc_c, pc_load_c, retired_c;

    // Only opcode and rd are consumed here; the rest belongs to the datapath.
    logic          unused_instr_bits;
    assign unused_instr_bits = ^bus.instr[31:12];

    opcode_classifier u_classifier (
        .opcode  (bus.instr[6:0]),
        .cls     (dec_cls),
        .illegal (dec_illegal),
        .system  (dec_system)
    );

    assign timeout_hit = TO_EN && (cnt_q == TO_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_NONE;
            rd_zero_q <= 1'b1;
            ill_q     <= 1'b0;
            berr_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_DECODE) begin
                cls_q     <= dec_cls;
                rd_zero_q <= (bus.instr[11:7] == 5'd0);
            end
            if (set_ill)  ill_q  <= 1'b1;
            if (set_berr) berr_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        set_ill    = 1'b0;
        set_berr   = 1'b0;
        pmem_req_c = 1'b0;
        ir_load_c  = 1'b0;
        opd_load_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        rf_we_c    = 1'b0;
        pc_inc_c   = 1'b0;
        pc_load_c  = 1'b0;
        retired_c  = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                pmem_req_c = 1'b1;
                if (bus.pmem_ready) begin
                    ir_load_c = 1'b1;
                    state_d   = ST_DECODE;
                end else if (timeout_hit) begin
                    set_berr = 1'b1;
                    state_d  = ST_TRAP;
                end
            end
            ST_DECODE: begin
                opd_load_c = 1'b1;
                if (dec_system) begin
                    state_d = ST_HALT;
                end else if (dec_illegal) begin
                    set_ill = 1'b1;
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (cls_q == CLS_BRANCH) begin
                    pc_load_c = bus.branch_taken;
                    pc_inc_c  = ~bus.branch_taken;
                    retired_c = 1'b1;
                    state_d   = ST_FETCH;
                end else if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
                    state_d = ST_MEMORY;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (cls_q == CLS_STORE);
                if (bus.dmem_ready) begin
                    if (cls_q == CLS_STORE) begin
                        pc_inc_c  = 1'b1;
                        retired_c = 1'b1;
                        state_d   = ST_FETCH;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (timeout_hit) begin
                    set_berr = 1'b1;
                    state_d  = ST_TRAP;
                end
            end
            ST_WRITEBACK: begin
                rf_we_c   = !rd_zero_q && (cls_q != CLS_FENCE);
                pc_load_c = is_jump(cls_q);
                pc_inc_c  = !is_jump(cls_q);
                retired_c = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // Counts only while staying in a waiting request state; any exit
    // (ready, trap) returns it to zero, so each FETCH/MEMORY starts fresh.
    always_comb begin
        cnt_d = '0;
        if (TO_EN && state_d == state_q &&
            ((state_q == ST_FETCH  && !bus.pmem_ready) ||
             (state_q == ST_MEMORY && !bus.dmem_ready))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Outputs are forced low combinationally during rst so an abandoned
    // instruction stops driving the datapath in the reset cycle itself.
    assign bus.pmem_req      = !rst && pmem_req_c;
    assign bus.ir_load       = !rst && ir_load_c;
    assign bus.opd_load      = !rst && opd_load_c;
    assign bus.dmem_req      = !rst && dmem_req_c;
    assign bus.dmem_we       = !rst && dmem_we_c;
    assign bus.rf_we         = !rst && rf_we_c;
    assign bus.pc_inc        = !rst && pc_inc_c;
    assign bus.pc_load       = !rst && pc_load_c;
    assign bus.instr_retired = !rst && retired_c;
    assign bus.halted        = !rst && (state_q == ST_HALT);
    assign bus.illegal_instr = !rst && ill_q;
    assign bus.bus_error     = !rst && berr_q;
    assign bus.state         = rst ? FETCH : state_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm (MEM_TIMEOUT=8). Stimulus pushes the
// hand-computed expected output vector of each cycle; the monitor pops and
// compares on the falling edge.
module tb_cpu_control_fsm;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cpu_control_fsm_if bus ();

    cpu_control_fsm #(.MEM_TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // control bit order: pmem_req ir_load opd_load dmem_req dmem_we rf_we
    //                    pc_inc pc_load retired halted illegal bus_error
    localparam logic [11:0] NONE = 12'h000;
    localparam logic [11:0] PREQ = 12'h800;
    localparam logic [11:0] IRL  = 12'h400;
    localparam logic [11:0] OPD  = 12'h200;
    localparam logic [11:0] DREQ = 12'h100;
    localparam logic [11:0] DWE  = 12'h080;
    localparam logic [11:0] RFWE = 12'h040;
    localparam logic [11:0] PCI  = 12'h020;
    localparam logic [11:0] PCL  = 12'h010;
    localparam logic [11:0] RET  = 12'h008;
    localparam logic [11:0] HLT  = 12'h004;
    localparam logic [11:0] ILL  = 12'h002;
    localparam logic [11:0] BERR = 12'h001;

    typedef struct {
        string       name;
        logic [14:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [14:0] act;
    int n_vec = 0;
    int n_err = 0;

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            act = {bus.state, bus.pmem_req, bus.ir_load, bus.opd_load,
                   bus.dmem_req, bus.dmem_we, bus.rf_we, bus.pc_inc,
                   bus.pc_load, bus.instr_retired, bus.halted,
                   bus.illegal_instr, bus.bus_error};
            n_vec++;
            if (act !== mon_e.val) begin
                n_err++;
                $display("FAIL %s: got state=%0d ctl=%03h, expected state=%0d ctl=%03h",
                         mon_e.name, act[14:12], act[11:0],
                         mon_e.val[14:12], mon_e.val[11:0]);
            end
        end
    end

    task automatic step(input string nm, input logic [2:0] st, input logic [11:0] ctl);
        exp_t e;
        e.name = nm;
        e.val  = {st, ctl};
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string pfx, input logic [31:0] ins);
        bus.instr = ins;
        step({pfx, "_fetch"}, FETCH, PREQ | IRL);
        step({pfx, "_decode"}, DECODE, OPD);
    endtask

    initial begin
        bus.instr        = 32'h0;
        bus.pmem_ready   = 1'b1;
        bus.dmem_ready   = 1'b0;
        bus.branch_taken = 1'b0;
        rst              = 1'b1;
        @(posedge clk);
        #1;

        step("reset0", FETCH, NONE);
        step("reset1", FETCH, NONE);
        rst = 1'b0;

        // ADD x3,x1,x2
        fetch_decode("add", 32'h002081B3);
        step("add_exec", EXECUTE, NONE);
        step("add_wb", WRITEBACK, RFWE | PCI | RET);

        // LW x2, ready on 4th MEMORY cycle
        fetch_decode("lw", 32'h0000A103);
        step("lw_exec", EXECUTE, NONE);
        bus.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_mem_wait", MEMORY, DREQ);
        bus.dmem_ready = 1'b1;
        step("lw_mem_rdy", MEMORY, DREQ);
        bus.dmem_ready = 1'b0;
        step("lw_wb", WRITEBACK, RFWE | PCI | RET);

        // BEQ taken / not taken
        bus.branch_taken = 1'b1;
        fetch_decode("beq_t", 32'h00208463);
        step("beq_t_exec", EXECUTE, PCL | RET);
        bus.branch_taken = 1'b0;
        fetch_decode("beq_n", 32'h00208463);
        step("beq_n_exec", EXECUTE, PCI | RET);

        // ADDI x0,x0,1: no register write
        fetch_decode("addi0", 32'h00100013);
        step("addi0_exec", EXECUTE, NONE);
        step("addi0_wb", WRITEBACK, PCI | RET);

        // SW with one wait cycle
        fetch_decode("sw", 32'h0020A023);
        step("sw_exec", EXECUTE, NONE);
        step("sw_mem_wait", MEMORY, DREQ | DWE);
        bus.dmem_ready = 1'b1;
        step("sw_mem_rdy", MEMORY, DREQ | DWE | PCI | RET);
        bus.dmem_ready = 1'b0;

        // JAL x1: register write plus PC load
        fetch_decode("jal", 32'h008000EF);
        step("jal_exec", EXECUTE, NONE);
        step("jal_wb", WRITEBACK, RFWE | PCL | RET);

        // FENCE with rd=1: never writes the register file
        fetch_decode("fence", 32'h0000008F);
        step("fence_exec", EXECUTE, NONE);
        step("fence_wb", WRITEBACK, PCI | RET);

        // Ready on the 8th (limit) cycle wins over the timeout
        bus.instr      = 32'h00100013;
        bus.pmem_ready = 1'b0;
        for (int i = 0; i < 7; i++) step("edge_fetch_wait", FETCH, PREQ);
        bus.pmem_ready = 1'b1;
        step("edge_fetch_rdy", FETCH, PREQ | IRL);
        step("edge_decode", DECODE, OPD);
        step("edge_exec", EXECUTE, NONE);
        step("edge_wb", WRITEBACK, PCI | RET);

        // Fetch timeout after 8 request cycles
        bus.pmem_ready = 1'b0;
        for (int i = 0; i < 8; i++) step("to_fetch_wait", FETCH, PREQ);
        bus.pmem_ready = 1'b1;
        step("to_trap0", TRAP, BERR);
        step("to_trap1", TRAP, BERR);

        rst = 1'b1;
        step("to_reset", FETCH, NONE);
        rst = 1'b0;

        // All-zero word is illegal
        fetch_decode("ill", 32'h00000000);
        step("ill_trap0", TRAP, ILL);
        step("ill_trap1", TRAP, ILL);

        rst = 1'b1;
        step("ill_reset", FETCH, NONE);
        rst = 1'b0;

        // EBREAK halts
        fetch_decode("ebreak", 32'h00100073);
        step("ebreak_halt0", HALT, HLT);
        step("ebreak_halt1", HALT, HLT);

        rst = 1'b1;
        step("halt_reset", FETCH, NONE);
        rst = 1'b0;

        // Reset abandons an in-flight load
        fetch_decode("rstm", 32'h0000A103);
        step("rstm_exec", EXECUTE, NONE);
        step("rstm_mem", MEMORY, DREQ);
        rst = 1'b1;
        bus.dmem_ready = 1'b1;
        step("rstm_rst", FETCH, NONE);
        rst = 1'b0;
        bus.dmem_ready = 1'b0;
        fetch_decode("rstm_add", 32'h002081B3);
        step("rstm_add_exec", EXECUTE, NONE);
        step("rstm_add_wb", WRITEBACK, RFWE | PCI | RET);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
